// File: rtl/ram2e_efb_responder.sv
// ram2e_efb_responder
//
// Wishbone responder that stands in for the MachXO2 EFB configuration/UFM
// block as seen by the RAM2E UFM controller. It decodes the small command
// set the controller issues through the configuration frame registers and
// keeps a byte-addressed UFM image organised as pages of 16 bytes.
//
// Register map:
//   0x70  frame control (write bit7: 1 = open frame, 0 = close/abort)
//         read returns {frame_open, 7'b0}
//   0x71  command / operand / data bytes (write only)
//   0x72  status read {cfg_en, frame_open, 6'b0}
//   0x73  read data from the current output command
//
// Ports:
//   C14M         clock, everything on the rising edge
//   nRST         asynchronous active-low reset (clears UFM to 0xFF)
//   wb_rst_i     synchronous soft reset (UFM contents kept)
//   wb_cyc_i     Wishbone cycle
//   wb_stb_i     Wishbone strobe
//   wb_we_i      1 = write, 0 = read
//   wb_adr_i     register address
//   wb_dat_i     write data
//   wb_dat_o     read data, valid while wb_ack_o is high
//   wb_ack_o     single-cycle transfer acknowledge
//   wbc_ufm_irq  single-cycle pulse when a page program completes
//   cfg_en_o     configuration interface enabled
//
// Parameters:
//   PAGE_BITS    page address width; the UFM holds 2**PAGE_BITS pages
//   ACK_WAIT     extra wait cycles before ack (ack latency = 1 + ACK_WAIT)

module ram2e_efb_responder #(
  parameter int PAGE_BITS = 2,
  parameter int ACK_WAIT  = 0
) (
  input  logic       C14M,
  input  logic       nRST,
  input  logic       wb_rst_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [7:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       wbc_ufm_irq,
  output logic       cfg_en_o
);

  localparam int NBYTES = 16 * (2 ** PAGE_BITS);
  localparam int CW     = (ACK_WAIT > 1) ? $clog2(ACK_WAIT + 1) : 1;

  localparam logic [7:0] OP_ENABLE  = 8'h74;
  localparam logic [7:0] OP_STATUS  = 8'h3C;
  localparam logic [7:0] OP_SETADDR = 8'hB4;
  localparam logic [7:0] OP_READ    = 8'hCA;
  localparam logic [7:0] OP_PROG    = 8'hC9;
  localparam logic [7:0] OP_DISABLE = 8'h26;
  localparam logic [7:0] OP_BYPASS  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_OPER,
    ST_DIN,
    ST_DOUT,
    ST_SKIP
  } state_t;

  state_t               state;
  logic [7:0]           op;
  logic [1:0]           oper_left;
  logic [3:0]           bcnt;
  logic [PAGE_BITS-1:0] page;
  logic [3:0]           idx;
  logic                 sa_ok;
  logic [7:0]           sa_b2;
  logic [7:0]           ufm [0:NBYTES-1];

  logic                 armed;
  logic                 pend;
  logic [CW-1:0]        cnt;
  logic [7:0]           lat_adr;
  logic                 lat_we;
  logic [7:0]           lat_dat;

  logic                 req;
  logic                 start;
  logic                 do_xfer;
  logic [7:0]           x_adr;
  logic                 x_we;
  logic [7:0]           x_dat;
  logic                 frame_open;
  logic [PAGE_BITS+3:0] ufm_addr;
  logic [7:0]           ufm_rd;
  logic [PAGE_BITS-1:0] sa_page;

  // A request is taken only while armed, so a strobe held across many
  // cycles executes once. With no extra wait the transfer happens on the
  // very edge the request is seen, using the live bus inputs; otherwise the
  // latched copy is used once the wait counter has run out.
  always_comb begin
    req        = wb_cyc_i & wb_stb_i;
    start      = req & armed & ~pend;
    do_xfer    = (ACK_WAIT == 0) ? start : (pend && (cnt == '0));
    x_adr      = (ACK_WAIT == 0) ? wb_adr_i : lat_adr;
    x_we       = (ACK_WAIT == 0) ? wb_we_i  : lat_we;
    x_dat      = (ACK_WAIT == 0) ? wb_dat_i : lat_dat;
    frame_open = (state != ST_IDLE);
    ufm_addr   = {page, idx};
    ufm_rd     = ufm[ufm_addr];
    sa_page    = PAGE_BITS'({sa_b2, x_dat});
  end

  // Handshake, register decode, command FSM and UFM image all live in one
  // block so every side effect lands on the same edge that raises ack.
  // The soft reset mirrors the hard reset except that the UFM image is kept.
  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= 8'h00;
      wbc_ufm_irq <= 1'b0;
      cfg_en_o    <= 1'b0;
      state       <= ST_IDLE;
      op          <= 8'h00;
      oper_left   <= 2'd0;
      bcnt        <= 4'd0;
      page        <= '0;
      idx         <= 4'd0;
      sa_ok       <= 1'b0;
      sa_b2       <= 8'h00;
      armed       <= 1'b1;
      pend        <= 1'b0;
      cnt         <= '0;
      lat_adr     <= 8'h00;
      lat_we      <= 1'b0;
      lat_dat     <= 8'h00;
      for (int i = 0; i < NBYTES; i++) ufm[i] <= 8'hFF;
    end else if (wb_rst_i) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= 8'h00;
      wbc_ufm_irq <= 1'b0;
      cfg_en_o    <= 1'b0;
      state       <= ST_IDLE;
      op          <= 8'h00;
      oper_left   <= 2'd0;
      bcnt        <= 4'd0;
      page        <= '0;
      idx         <= 4'd0;
      sa_ok       <= 1'b0;
      sa_b2       <= 8'h00;
      armed       <= 1'b1;
      pend        <= 1'b0;
      cnt         <= '0;
      lat_adr     <= 8'h00;
      lat_we      <= 1'b0;
      lat_dat     <= 8'h00;
    end else begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= 8'h00;
      wbc_ufm_irq <= 1'b0;

      if (!req) armed <= 1'b1;

      if (start) begin
        armed   <= 1'b0;
        lat_adr <= wb_adr_i;
        lat_we  <= wb_we_i;
        lat_dat <= wb_dat_i;
        if (ACK_WAIT != 0) begin
          pend <= 1'b1;
          cnt  <= CW'(ACK_WAIT - 1);
        end
      end else if (pend && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end

      if (do_xfer) begin
        pend     <= 1'b0;
        wb_ack_o <= 1'b1;
        case (x_adr)
          8'h70: begin
            if (x_we) begin
              if (x_dat[7]) begin
                state <= ST_CMD;
                idx   <= 4'd0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              wb_dat_o <= {frame_open, 7'b0};
            end
          end

          8'h71: begin
            if (x_we) begin
              case (state)
                ST_CMD: begin
                  op   <= x_dat;
                  bcnt <= 4'd0;
                  case (x_dat)
                    OP_ENABLE, OP_STATUS: begin
                      oper_left <= 2'd3;
                      state     <= ST_OPER;
                    end
                    OP_SETADDR, OP_READ, OP_PROG: begin
                      if (cfg_en_o) begin
                        oper_left <= 2'd3;
                        state     <= ST_OPER;
                      end else begin
                        state <= ST_SKIP;
                      end
                    end
                    OP_DISABLE: begin
                      oper_left <= 2'd2;
                      state     <= ST_OPER;
                    end
                    OP_BYPASS: begin
                      cfg_en_o <= 1'b0;
                      state    <= ST_SKIP;
                    end
                    default: state <= ST_SKIP;
                  endcase
                end

                // Operand values carry nothing this model needs; only the
                // count matters. The last operand launches the command body.
                ST_OPER: begin
                  if (oper_left == 2'd1) begin
                    case (op)
                      OP_ENABLE: begin
                        cfg_en_o <= 1'b1;
                        state    <= ST_SKIP;
                      end
                      OP_DISABLE: begin
                        cfg_en_o <= 1'b0;
                        state    <= ST_SKIP;
                      end
                      OP_STATUS, OP_READ:  state <= ST_DOUT;
                      OP_SETADDR, OP_PROG: state <= ST_DIN;
                      default:             state <= ST_SKIP;
                    endcase
                  end else begin
                    oper_left <= oper_left - 2'd1;
                  end
                end

                // Set-address takes four bytes; only byte 0 (must be 0x40)
                // and bytes 2..3 (page number) are meaningful. Program writes
                // straight into the image and wraps up after 16 bytes.
                ST_DIN: begin
                  bcnt <= bcnt + 4'd1;
                  if (op == OP_SETADDR) begin
                    if (bcnt == 4'd0) sa_ok <= (x_dat == 8'h40);
                    if (bcnt == 4'd2) sa_b2 <= x_dat;
                    if (bcnt == 4'd3) begin
                      if (sa_ok) page <= sa_page;
                      idx   <= 4'd0;
                      state <= ST_SKIP;
                    end
                  end else begin
                    ufm[ufm_addr] <= x_dat;
                    idx           <= idx + 4'd1;
                    if (bcnt == 4'd15) begin
                      wbc_ufm_irq <= 1'b1;
                      page        <= page + PAGE_BITS'(1);
                      state       <= ST_SKIP;
                    end
                  end
                end

                default: ;
              endcase
            end
          end

          8'h72: begin
            if (!x_we) wb_dat_o <= {cfg_en_o, frame_open, 6'b0};
          end

          // Status output saturates at byte 4 so every read past the
          // status word keeps returning zero. UFM output walks the image
          // linearly, rolling over into the next page.
          8'h73: begin
            if (!x_we && (state == ST_DOUT)) begin
              if (op == OP_STATUS) begin
                if (bcnt == 4'd3) wb_dat_o <= {6'b0, cfg_en_o, 1'b0};
                if (bcnt != 4'd4) bcnt <= bcnt + 4'd1;
              end else begin
                wb_dat_o <= ufm_rd;
                idx      <= idx + 4'd1;
                if (idx == 4'd15) page <= page + PAGE_BITS'(1);
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ram2e_efb_responder.md
Name: ram2e_efb_responder

Overview:
- Wishbone responder emulating the MachXO2 EFB configuration/UFM subset that the RAM2E UFM controller drives: frame control at 0x70, command/operand/data bytes at 0x71, status at 0x72, read data at 0x73.
- Holds a small byte-addressed UFM image (pages of 16 bytes).
- Used as a drop-in for the hard EFB on parts without one, and as the bench model for the UFM controller.

Parameters:
- PAGE_BITS, 2, UFM page-address width; UFM holds 2^PAGE_BITS pages of 16 bytes.
- ACK_WAIT, 0, extra wait cycles before ack; ack latency = 1+ACK_WAIT cycles.

Ports:
- C14M  in  1  clock; all logic on rising edge.
- nRST  in  1  asynchronous active-low reset.
- wb_rst_i  in  1  synchronous soft reset; same effect as nRST except UFM contents are kept.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe; transfer requested when cyc&stb.
- wb_we_i  in  1  1=write, 0=read.
- wb_adr_i  in  8  register address.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data, valid while wb_ack_o=1.
- wb_ack_o  out  1  one-cycle transfer acknowledge.
- wbc_ufm_irq  out  1  one-cycle pulse when a page program completes.
- cfg_en_o  out  1  configuration interface enabled.

Behaviour:
- Reset (nRST low, async): wb_ack_o=0, wb_dat_o=0x00, wbc_ufm_irq=0, cfg_en_o=0, FSM=IDLE, page addr=0, byte idx=0, all UFM bytes=0xFF.
- wb_rst_i: same as nRST, but UFM contents are kept.
- Handshake:
  - On the first cycle cyc&stb is high while armed, latch adr/we/dat, count ACK_WAIT cycles, then assert ack for exactly 1 cycle and disarm.
  - Re-arm only after a cycle with cyc&stb low. A held strobe therefore executes exactly once.
  - Side effects (state, memory) take effect in the ack cycle.
- Registers:
  - 0x70 write: bit7=1 opens frame (FSM->CMD, byte idx=0); bit7=0 closes frame (FSM->IDLE from any state, abort).
  - 0x70 read: {frame_open,7'b0}.
  - 0x72 read: {cfg_en, frame_open, 6'b0}.
  - 0x71 write: byte into FSM; ignored in IDLE.
  - 0x73 read: next output byte per FSM; 0x00 if none.
  - All other reads return 0x00; all other writes are ignored.
- FSM states: IDLE, CMD, OPER(n), DIN, DOUT, SKIP.
  - CMD on opcode:
    - 0x74: 3 operands, then cfg_en=1.
    - 0x3C: 3 operands, then DOUT status.
    - 0xB4: 3 operands, then DIN 4 bytes (set address).
    - 0xCA: 3 operands, then DOUT UFM.
    - 0xC9: 3 operands, then DIN 16 bytes (program).
    - 0x26: 2 operands, then cfg_en=0.
    - 0xFF: cfg_en=0 immediately, then SKIP.
    - Any other opcode: SKIP.
    - 0xB4/0xCA/0xC9 while cfg_en=0: SKIP.
  - Operand values are ignored.
  - After a command completes, further 0x71 bytes are ignored (SKIP) until frame close.
  - Status DOUT returns 0x00, 0x00, 0x00, {6'b0,cfg_en,1'b0}, then 0x00 thereafter.
  - Set address: page = {byte2,byte3}[PAGE_BITS-1:0] if byte0==0x40; otherwise the page is unchanged. Byte idx=0.
  - UFM DOUT returns ufm[page][idx]; idx++. When idx wraps 15->0, page++ modulo 2^PAGE_BITS.
  - Program DIN writes ufm[page][idx] directly; idx++. After the 16th byte: wbc_ufm_irq pulses, page++ (wrap), FSM->SKIP.
  - Frame close mid-program: bytes already written remain; page is not incremented; no irq.
- A read of 0x73 in any state other than DOUT returns 0x00 and has no side effect.

Test Plan:
- Ack rule: hold cyc=stb=1 on a 0x70 write of 0x80 for 10 cycles -> exactly one ack, 1 cycle after strobe; with ACK_WAIT=2, ack at cycle 3.
- Enable: open; write 0x71 0x74,0x08,0x00,0x00; close -> cfg_en_o=1. Status sequence 0x3C+3 operands -> 0x73 reads 00,00,00,02, then 00.
- Program/read: set address {0x40,0,0,1}; program 16 bytes 0x10..0x1F -> irq pulse. Set page 1; 0xCA -> reads 0x10..0x1F; 17th read = ufm[2][0] = 0xFF.
- Gating: with cfg_en=0, 0xCA+operands -> 0x73 reads 0x00; memory unchanged.
- Abort: frame close after 5 program bytes -> those 5 bytes stored, rest 0xFF, no irq.
- Reset: nRST low mid-DOUT -> outputs 0, cfg_en_o=0, memory all 0xFF. wb_rst_i instead -> memory preserved.
